mat_stream_loader: RTL and testbench

- Transmitter side of the whole-matrix stb/ack protocol that the linalg blocks consume.
- Accepts 32-bit elements one per handshake from a word-serial source (host link, memory reader, activation stream).
- Assembles them into a full M x N matrix, then presents it on a packed output bus with output_mat_stb until the downstream consumer acknowledges.
- Typical placement: directly driving input_mat_1/input_mat_2 of a matrix product unit, with TRANSPOSE set when the source streams column-major.

---
 rtl/mat_stream_loader_if.sv | 50 +++++
 rtl/mat_stream_loader.sv | 128 ++++++++++++
 tb/tb_mat_stream_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mat_stream_loader_if.sv
// mat_stream_loader_if
//   Bundles the element-stream input handshake and the whole-matrix output
//   handshake of the matrix stream loader.
//
//   Signals:
//     input_elem      32-bit element from the word-serial source
//     input_elem_stb  source has a valid element
//     input_elem_ack  loader can take an element this cycle
//     output_mat      assembled matrix, stored [row][col]
//     output_mat_stb  output_mat is complete and valid
//     output_mat_ack  consumer takes the matrix
//     elem_index      elements accepted into the current matrix
//
//   Modports:
//     master  the environment (element source plus matrix consumer)
//     slave   the loader itself
interface mat_stream_loader_if #(
    parameter int M = 1,
    parameter int N = 1
);
    localparam int IDX_W = $clog2(M * N + 1);

    logic [31:0]                input_elem;
    logic                       input_elem_stb;
    logic                       input_elem_ack;
    logic [M-1:0][N-1:0][31:0]  output_mat;
    logic                       output_mat_stb;
    logic                       output_mat_ack;
    logic [IDX_W-1:0]           elem_index;

    modport master (
        output input_elem,
        output input_elem_stb,
        output output_mat_ack,
        input  input_elem_ack,
        input  output_mat,
        input  output_mat_stb,
        input  elem_index
    );

    modport slave (
        input  input_elem,
        input  input_elem_stb,
        input  output_mat_ack,
        output input_elem_ack,
        output output_mat,
        output output_mat_stb,
        output elem_index
    );
endinterface

// File: rtl/mat_stream_loader.sv
// mat_stream_loader
//   Collects 32-bit elements one per stb/ack handshake into an M x N matrix,
//   then presents the whole matrix with output_mat_stb until the consumer
//   acknowledges it. With TRANSPOSE=1 the incoming stream is column-major;
//   the stored matrix is always indexed [row][col].
//
//   Ports:
//     clk  rising-edge clock for all state
//     rst  asynchronous reset, active low
//     bus  mat_stream_loader_if slave view (element input handshake,
//          matrix output handshake, elem_index progress count)
module mat_stream_loader #(
    parameter int M         = 1,
    parameter int N         = 1,
    parameter int TRANSPOSE = 0
) (
    input  logic                clk,
    input  logic                rst,
    mat_stream_loader_if.slave  bus
);

    localparam int IDX_W = $clog2(M * N + 1);
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int COL_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_PUT  = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M * N - 1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(M * N);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(M - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);

    logic [0:0]                 state_q, state_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       ack_q, ack_d;
    logic                       stb_q, stb_d;
    logic [M-1:0][N-1:0][31:0]  mat_q, mat_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        ack_d   = ack_q;
        stb_d   = stb_q;
        mat_d   = mat_q;

        case (state_q)
            ST_LOAD: begin
                // ack rises on the first edge after reset and then stays up,
                // giving one element per cycle while the source keeps stb high.
                ack_d = 1'b1;
                if (bus.input_elem_stb && ack_q) begin
                    mat_d[row_q][col_q] = bus.input_elem;
                    if (idx_q == LAST_IDX) begin
                        // The last element is written on the same edge that
                        // raises the matrix strobe.
                        ack_d   = 1'b0;
                        stb_d   = 1'b1;
                        idx_d   = FULL_IDX;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = ST_PUT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (TRANSPOSE == 0) begin
                            if (col_q == LAST_COL) begin
                                col_d = '0;
                                row_d = row_q + ROW_W'(1);
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end else begin
                            if (row_q == LAST_ROW) begin
                                row_d = '0;
                                col_d = col_q + COL_W'(1);
                            end else begin
                                row_d = row_q + ROW_W'(1);
                            end
                        end
                    end
                end
            end

            ST_PUT: begin
                // stb is always high here, so ack alone completes the transfer.
                // The matrix is left in place; the next one overwrites it.
                if (bus.output_mat_ack) begin
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            stb_q   <= 1'b0;
            mat_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            stb_q   <= stb_d;
            mat_q   <= mat_d;
        end
    end

    assign bus.input_elem_ack = ack_q;
    assign bus.output_mat_stb = stb_q;
    assign bus.output_mat     = mat_q;
    assign bus.elem_index     = idx_q;

endmodule

// File: tb/tb_mat_stream_loader.sv
// tb_mat_stream_loader
//   Drives four loader configurations side by side (2x3 row-major,
//   2x3 column-major, 2x2, 1x1) from per-instance element tables and compares
//   every output each cycle against a reference model that places the k-th
//   accepted element by plain row/column arithmetic.
module tb_mat_stream_loader;

    logic        clk = 1'b0;
    logic        rstN   [4];
    logic        stbIn  [4];
    logic        outAck [4];
    logic [31:0] srcVal [4][256];
    bit          checkEn = 1'b0;

    int compareCount  = 0;
    int mismatchCount = 0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, actual, actual, expected, expected);
        end
    endtask

    // Advance a number of cycles; inputs change 1 time unit after each rising edge.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int M = (g == 3) ? 1 : 2;
        localparam int N = (g <= 1) ? 3 : (g == 2) ? 2 : 1;
        localparam int T = (g == 1) ? 1 : 0;

        mat_stream_loader_if #(.M(M), .N(N)) bus ();

        logic       rstL;
        logic [7:0] srcPtr = '0;

        assign rstL                = rstN[g];
        assign bus.input_elem_stb  = stbIn[g];
        assign bus.output_mat_ack  = outAck[g];
        assign bus.input_elem      = srcVal[g][srcPtr];

        mat_stream_loader #(.M(M), .N(N), .TRANSPOSE(T)) dut (
            .clk (clk),
            .rst (rstL),
            .bus (bus)
        );

        // Reference model: count accepted elements, drop the k-th one at its
        // row/col position computed by division, full after M*N elements.
        int          cnt    = 0;
        bit          expAck = 1'b0;
        bit          expStb = 1'b0;
        logic [31:0] expMat [M*N];

        always @(posedge clk or negedge rstL) begin
            if (!rstL) begin
                cnt    = 0;
                expAck = 1'b0;
                expStb = 1'b0;
                for (int k = 0; k < M * N; k++) expMat[k] = '0;
            end else if (expStb) begin
                if (outAck[g]) begin
                    expStb = 1'b0;
                    expAck = 1'b1;
                    cnt    = 0;
                end
            end else if (expAck && stbIn[g]) begin
                int r;
                int c;
                r = (T == 1) ? (cnt % M) : (cnt / N);
                c = (T == 1) ? (cnt / M) : (cnt % N);
                expMat[r * N + c] = bus.input_elem;
                srcPtr <= srcPtr + 8'd1;
                cnt++;
                if (cnt == M * N) begin
                    expStb = 1'b1;
                    expAck = 1'b0;
                end else begin
                    expAck = 1'b1;
                end
            end else begin
                expAck = 1'b1;
            end
        end

        always @(negedge clk) begin
            if (checkEn) begin
                checkOutput($sformatf("c%0d.ack", g), 32'(bus.input_elem_ack), 32'(expAck));
                checkOutput($sformatf("c%0d.stb", g), 32'(bus.output_mat_stb), 32'(expStb));
                checkOutput($sformatf("c%0d.idx", g), 32'(bus.elem_index), 32'(cnt));
                for (int r = 0; r < M; r++)
                    for (int c = 0; c < N; c++)
                        checkOutput($sformatf("c%0d.mat[%0d][%0d]", g, r, c),
                                    bus.output_mat[r][c], expMat[r * N + c]);
            end
        end
    end

    initial begin
        for (int g = 0; g < 4; g++) begin
            rstN[g]   = 1'b0;
            stbIn[g]  = 1'b0;
            outAck[g] = 1'b0;
            for (int k = 0; k < 256; k++) srcVal[g][k] = $urandom;
        end
        for (int k = 0; k < 6; k++) begin
            srcVal[0][k] = 32'(k + 1);
            srcVal[1][k] = 32'(k + 1);
        end
        srcVal[0][6] = 32'd99;
        srcVal[2][0] = 32'd10;
        srcVal[2][1] = 32'd20;
        srcVal[2][2] = 32'd30;
        srcVal[2][3] = 32'd40;
        srcVal[3][0] = 32'd5;
        srcVal[3][1] = 32'd7;

        applyStimulus(3);
        checkEn = 1'b1;
        checkOutput("rst.ack", 32'(cfg[0].bus.input_elem_ack), 32'd0);
        checkOutput("rst.stb", 32'(cfg[0].bus.output_mat_stb), 32'd0);
        checkOutput("rst.idx", 32'(cfg[0].bus.elem_index), 32'd0);

        // Continuous streams on 0/1, toggling stb on 2, ack-held-high on 3.
        for (int g = 0; g < 4; g++) rstN[g] = 1'b1;
        stbIn[0]  = 1'b1;
        stbIn[1]  = 1'b1;
        stbIn[3]  = 1'b1;
        outAck[3] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            stbIn[2] = (i % 2 == 0);
            applyStimulus(1);
        end
        stbIn[2] = 1'b0;

        checkOutput("rm.stb",     32'(cfg[0].bus.output_mat_stb), 32'd1);
        checkOutput("rm.idx",     32'(cfg[0].bus.elem_index), 32'd6);
        checkOutput("rm.m00",     cfg[0].bus.output_mat[0][0], 32'd1);
        checkOutput("rm.m02",     cfg[0].bus.output_mat[0][2], 32'd3);
        checkOutput("rm.m10",     cfg[0].bus.output_mat[1][0], 32'd4);
        checkOutput("rm.m12",     cfg[0].bus.output_mat[1][2], 32'd6);
        checkOutput("cm.m10",     cfg[1].bus.output_mat[1][0], 32'd2);
        checkOutput("cm.m01",     cfg[1].bus.output_mat[0][1], 32'd3);
        checkOutput("cm.m02",     cfg[1].bus.output_mat[0][2], 32'd5);
        checkOutput("cm.m11",     cfg[1].bus.output_mat[1][1], 32'd4);
        checkOutput("gap.m00",    cfg[2].bus.output_mat[0][0], 32'd10);
        checkOutput("gap.m01",    cfg[2].bus.output_mat[0][1], 32'd20);
        checkOutput("gap.m10",    cfg[2].bus.output_mat[1][0], 32'd30);
        checkOutput("gap.m11",    cfg[2].bus.output_mat[1][1], 32'd40);
        checkOutput("gap.idx",    32'(cfg[2].bus.elem_index), 32'd4);

        // Backpressure: consumer stalls while the source keeps offering 99.
        applyStimulus(20);
        checkOutput("bp.ack",     32'(cfg[0].bus.input_elem_ack), 32'd0);
        checkOutput("bp.m12",     cfg[0].bus.output_mat[1][2], 32'd6);
        outAck[0] = 1'b1;
        applyStimulus(1);
        outAck[0] = 1'b0;
        checkOutput("bp.stbDrop", 32'(cfg[0].bus.output_mat_stb), 32'd0);
        checkOutput("bp.ackBack", 32'(cfg[0].bus.input_elem_ack), 32'd1);
        applyStimulus(8);
        checkOutput("bp.m00new",  cfg[0].bus.output_mat[0][0], 32'd99);

        // Reset in the middle of a load: release matrix, accept two, reset.
        outAck[2] = 1'b1;
        stbIn[2]  = 1'b1;
        applyStimulus(1);
        outAck[2] = 1'b0;
        applyStimulus(2);
        stbIn[2]  = 1'b0;
        checkOutput("mid.idx2",   32'(cfg[2].bus.elem_index), 32'd2);
        #2;
        rstN[2] = 1'b0;
        #1;
        checkOutput("mid.ack",    32'(cfg[2].bus.input_elem_ack), 32'd0);
        checkOutput("mid.stb",    32'(cfg[2].bus.output_mat_stb), 32'd0);
        checkOutput("mid.idx",    32'(cfg[2].bus.elem_index), 32'd0);
        checkOutput("mid.m00",    cfg[2].bus.output_mat[0][0], 32'd0);
        @(posedge clk);
        #1;
        rstN[2]  = 1'b1;
        stbIn[2] = 1'b1;
        applyStimulus(6);
        checkOutput("mid.full",   32'(cfg[2].bus.output_mat_stb), 32'd1);

        // Random traffic with occasional asynchronous resets on every instance.
        for (int i = 0; i < 3000; i++) begin
            for (int g = 0; g < 4; g++) begin
                stbIn[g]  = ($urandom_range(0, 3) != 0);
                outAck[g] = ($urandom_range(0, 2) == 0);
                rstN[g]   = ($urandom_range(0, 299) != 0);
            end
            applyStimulus(1);
        end
        for (int g = 0; g < 4; g++) rstN[g] = 1'b1;
        applyStimulus(2);

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
